sram_1w1r_macro_model: RTL and testbench

- Synthesizable, cycle-accurate responder model of a FreePDK45 OpenRAM 1W1R macro.
- Accepts the macro-side port set that the *_ext wrappers drive: active-low chip selects, one write port, one read port, per-lane write mask.
- Replaces the hard macro in RTL simulation and FPGA builds.
- Adds a post-reset clear sweep, a ready indication and same-address collision accounting so wrapper-level behaviour can be checked end to end.

---
 rtl/sram_model_pkg.sv | 54 +++++
 rtl/sram_1w1r_macro_model_if.sv | 39 +++
 rtl/sram_model_storage.sv | 57 +++++
 rtl/sram_1w1r_macro_model.sv | 164 ++++++++++++++++
 tb/tb_sram_1w1r_macro_model.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_model_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_model_pkg
//  Purpose  : Shared types and helpers for the 1W1R SRAM macro model.
//             Holds the controller state encoding, the lane width and depth
//             helpers, and the write-mask lane merge function.
//  Revision : 1.0  initial release
// ============================================================================
package sram_model_pkg;

    // The lane merge below works on fixed-width containers so that one
    // function serves every parameterisation. DATA_WIDTH must stay below
    // MAX_DATA_WIDTH and NUM_WMASK must not exceed MAX_WMASK.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_WMASK      = 32;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } sram_state_e;

    function automatic int lane_width(input int data_width, input int num_wmask);
        return data_width / num_wmask;
    endfunction

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Bit b belongs to lane b/lw. Bits of enabled lanes take new_word,
    // all other bits keep old_word.
    function automatic logic [MAX_DATA_WIDTH-1:0] lane_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_WMASK-1:0]      mask,
        input int                        num_wmask,
        input int                        lw
    );
        logic [MAX_DATA_WIDTH-1:0] merged;
        int                        lane;
        merged = old_word;
        for (int b = 0; b < MAX_DATA_WIDTH; b++) begin
            lane = b / lw;
            if (lane < num_wmask) begin
                if (mask[lane[4:0]]) begin
                    merged[b[7:0]] = new_word[b[7:0]];
                end
            end
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_1w1r_macro_model_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_1w1r_macro_model_if
//  Purpose  : Macro-side port bundle of an OpenRAM 1W1R macro plus the
//             model's status outputs.
//  Ports    : csb0/addr0/din0/wmask0  write port (active-low select)
//             csb1/addr1/dout1        read port  (active-low select)
//             ready/collision/collision_cnt  model status
//  Modports : master drives the macro pins, slave is the macro model.
//  Revision : 1.0  initial release
// ============================================================================
interface sram_1w1r_macro_model_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 44,
    parameter int NUM_WMASK  = 4,
    parameter int CNT_WIDTH  = 16
);
    logic                  csb0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [NUM_WMASK-1:0]  wmask0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  ready;
    logic                  collision;
    logic [CNT_WIDTH-1:0]  collision_cnt;

    modport master (
        output csb0, addr0, din0, wmask0, csb1, addr1,
        input  dout1, ready, collision, collision_cnt
    );

    modport slave (
        input  csb0, addr0, din0, wmask0, csb1, addr1,
        output dout1, ready, collision, collision_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sram_model_storage.sv
`default_nettype none
// ============================================================================
//  Module   : sram_model_storage
//  Purpose  : Plain word array with one full-width write port, one
//             registered read port and a combinational peek port used for
//             read-modify-write lane merging.
//  Ports    : clk, rst            clock, sync active-high reset (read reg)
//             i_we/i_waddr/i_wdata  full-word write
//             i_peek_addr/o_peek_data  current contents at the write address
//             i_re/i_raddr/o_rdata     registered read, 1-cycle latency
//  Revision : 1.0  initial release
// ============================================================================
module sram_model_storage
    import sram_model_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 44
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_we,
    input  wire logic [ADDR_WIDTH-1:0] i_waddr,
    input  wire logic [DATA_WIDTH-1:0] i_wdata,
    input  wire logic [ADDR_WIDTH-1:0] i_peek_addr,
    output logic      [DATA_WIDTH-1:0] o_peek_data,
    input  wire logic                  i_re,
    input  wire logic [ADDR_WIDTH-1:0] i_raddr,
    output logic      [DATA_WIDTH-1:0] o_rdata
);
    localparam int c_depth = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [DATA_WIDTH-1:0] r_rdata;

    // The array itself carries no reset; contents are defined by the
    // controller's clear sweep.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Non-blocking sampling means a same-edge write to the read address
    // is not yet visible: the read returns the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_peek_data = r_mem[i_peek_addr];
    assign o_rdata     = r_rdata;

endmodule
`default_nettype wire

// File: rtl/sram_1w1r_macro_model.sv
`default_nettype none
// ============================================================================
//  Module   : sram_1w1r_macro_model
//  Purpose  : Cycle-accurate responder model of a 1W1R OpenRAM macro with
//             post-reset clear sweep, ready flag and same-address
//             read/write collision accounting.
//  Ports    : clock   single clock for both macro ports
//             reset   synchronous, active-high
//             bus     slave side of sram_1w1r_macro_model_if
//                     (csb0/addr0/din0/wmask0 write, csb1/addr1/dout1 read,
//                      ready, collision pulse, saturating collision_cnt)
//  Revision : 1.0  initial release
// ============================================================================
module sram_1w1r_macro_model
    import sram_model_pkg::*;
#(
    parameter int ADDR_WIDTH     = 7,
    parameter int DATA_WIDTH     = 44,
    parameter int NUM_WMASK      = 4,
    parameter int CLEAR_ON_RESET = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  wire logic               clock,
    input  wire logic               reset,
    sram_1w1r_macro_model_if.slave  bus
);
    localparam int                    c_lw          = lane_width(DATA_WIDTH, NUM_WMASK);
    localparam logic [ADDR_WIDTH-1:0] c_last_addr   = '1;
    localparam sram_state_e           c_reset_state = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    sram_state_e           r_state;
    sram_state_e           w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_addr;
    logic [ADDR_WIDTH-1:0] w_clr_addr_nxt;

    logic                  w_ready;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_re;
    logic [DATA_WIDTH-1:0] w_old_word;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_coll;

    logic [MAX_DATA_WIDTH-1:0] w_old_ext;
    logic [MAX_DATA_WIDTH-1:0] w_din_ext;
    logic [MAX_WMASK-1:0]      w_mask_ext;
    logic [MAX_DATA_WIDTH-1:0] w_merged_ext;
    logic                      w_unused_merged_hi;

    logic                  r_collision;
    logic [CNT_WIDTH-1:0]  r_collision_cnt;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_reset_state;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            ST_CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (r_clr_addr == c_last_addr) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_state_nxt = ST_READY;
            end
            default: begin
                w_state_nxt = c_reset_state;
            end
        endcase
    end

    // Ready is also forced low while reset is held so that a model built
    // without the clear sweep still reports not-ready during reset.
    always_comb begin
        w_ready = 1'b0;
        w_we    = 1'b0;
        w_waddr = bus.addr0;
        w_wdata = w_merged;
        w_re    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_we    = !reset;
                w_waddr = r_clr_addr;
                w_wdata = '0;
            end
            ST_READY: begin
                w_ready = !reset;
                w_we    = !reset && !bus.csb0 && (|bus.wmask0);
                w_re    = !reset && !bus.csb1;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------- lane merge
    always_comb begin
        w_old_ext                       = '0;
        w_din_ext                       = '0;
        w_mask_ext                      = '0;
        w_old_ext[DATA_WIDTH-1:0]       = w_old_word;
        w_din_ext[DATA_WIDTH-1:0]       = bus.din0;
        w_mask_ext[NUM_WMASK-1:0]       = bus.wmask0;
        w_merged_ext = lane_merge(w_old_ext, w_din_ext, w_mask_ext, NUM_WMASK, c_lw);
    end

    assign w_merged           = w_merged_ext[DATA_WIDTH-1:0];
    assign w_unused_merged_hi = ^w_merged_ext[MAX_DATA_WIDTH-1:DATA_WIDTH];

    // ------------------------------------------------------------- storage
    sram_model_storage #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_storage (
        .clk         (clock),
        .rst         (reset),
        .i_we        (w_we),
        .i_waddr     (w_waddr),
        .i_wdata     (w_wdata),
        .i_peek_addr (bus.addr0),
        .o_peek_data (w_old_word),
        .i_re        (w_re),
        .i_raddr     (bus.addr1),
        .o_rdata     (w_rdata)
    );

    // ----------------------------------------------------------- collision
    // A write with an all-zero mask changes nothing and so cannot collide.
    assign w_coll = w_ready && !bus.csb0 && !bus.csb1 &&
                    (bus.addr0 == bus.addr1) && (|bus.wmask0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_collision     <= 1'b0;
            r_collision_cnt <= '0;
        end else begin
            r_collision <= w_coll;
            if (w_coll && (r_collision_cnt != {CNT_WIDTH{1'b1}})) begin
                r_collision_cnt <= r_collision_cnt + 1'b1;
            end
        end
    end

    assign bus.dout1         = w_rdata;
    assign bus.ready         = w_ready;
    assign bus.collision     = r_collision;
    assign bus.collision_cnt = r_collision_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sram_1w1r_macro_model.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_1w1r_macro_model
//  Purpose  : Self-checking bench for sram_1w1r_macro_model. Two instances
//             share one stimulus stream: one with a 16-bit collision counter
//             and one with a 2-bit counter to exercise saturation.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sram_1w1r_macro_model;

    localparam int AW    = 7;
    localparam int DW    = 44;
    localparam int NM    = 4;
    localparam int LW    = DW / NM;
    localparam int DEPTH = 1 << AW;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset;
    logic          csb0;
    logic          csb1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] din0;
    logic [NM-1:0] wmask0;

    sram_1w1r_macro_model_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASK(NM), .CNT_WIDTH(16)) bus_a ();
    sram_1w1r_macro_model_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASK(NM), .CNT_WIDTH(2))  bus_b ();

    assign bus_a.csb0   = csb0;
    assign bus_a.addr0  = addr0;
    assign bus_a.din0   = din0;
    assign bus_a.wmask0 = wmask0;
    assign bus_a.csb1   = csb1;
    assign bus_a.addr1  = addr1;
    assign bus_b.csb0   = csb0;
    assign bus_b.addr0  = addr0;
    assign bus_b.din0   = din0;
    assign bus_b.wmask0 = wmask0;
    assign bus_b.csb1   = csb1;
    assign bus_b.addr1  = addr1;

    sram_1w1r_macro_model #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASK(NM), .CLEAR_ON_RESET(1), .CNT_WIDTH(16)
    ) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    sram_1w1r_macro_model #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASK(NM), .CLEAR_ON_RESET(1), .CNT_WIDTH(2)
    ) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    // Reference model: memory contents, remaining not-ready cycles and the
    // expected outputs after the most recent edge.
    logic [DW-1:0] m_mem [DEPTH];
    int            busy_left;
    logic [DW-1:0] e_dout;
    logic          e_coll;
    logic          e_ready;
    int            e_cnt_a;
    int            e_cnt_b;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        csb0   = 1'b1;
        csb1   = 1'b1;
        addr0  = '0;
        addr1  = '0;
        din0   = '0;
        wmask0 = '0;
    endtask

    // One clock: advance the model with the inputs present at the edge,
    // then compare both instances 1 ns later.
    task automatic cycle();
        logic hit;
        @(posedge clock);
        if (reset) begin
            busy_left = DEPTH;
            e_dout    = '0;
            e_coll    = 1'b0;
            e_cnt_a   = 0;
            e_cnt_b   = 0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (busy_left > 0) begin
            busy_left--;
            e_coll = 1'b0;
        end else begin
            hit = !csb0 && !csb1 && (addr0 == addr1) && (wmask0 != '0);
            if (!csb1) e_dout = m_mem[addr1];
            if (!csb0) begin
                for (int l = 0; l < NM; l++) begin
                    if (wmask0[l]) m_mem[addr0][l*LW +: LW] = din0[l*LW +: LW];
                end
            end
            e_coll = hit;
            if (hit) begin
                if (e_cnt_a < 65535) e_cnt_a++;
                if (e_cnt_b < 3)     e_cnt_b++;
            end
        end
        #1;
        e_ready = !reset && (busy_left == 0);
        check("ready_a", 64'(bus_a.ready),         64'(e_ready));
        check("ready_b", 64'(bus_b.ready),         64'(e_ready));
        check("dout_a",  64'(bus_a.dout1),         64'(e_dout));
        check("dout_b",  64'(bus_b.dout1),         64'(e_dout));
        check("coll_a",  64'(bus_a.collision),     64'(e_coll));
        check("coll_b",  64'(bus_b.collision),     64'(e_coll));
        check("cnt_a",   64'(bus_a.collision_cnt), 64'(e_cnt_a));
        check("cnt_b",   64'(bus_b.collision_cnt), 64'(e_cnt_b));
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [NM-1:0] m);
        idle();
        csb0   = 1'b0;
        addr0  = AW'(a);
        din0   = d;
        wmask0 = m;
        cycle();
        idle();
    endtask

    task automatic rd(input int a, output logic [DW-1:0] v);
        idle();
        csb1  = 1'b0;
        addr1 = AW'(a);
        cycle();
        idle();
        v = bus_a.dout1;
    endtask

    // Cycles from reset release until ready rises, bounded.
    task automatic sweep_len(output int k);
        k = 0;
        while (k < 300) begin
            cycle();
            k++;
            if (bus_a.ready === 1'b1) break;
        end
    endtask

    task automatic rand_inputs();
        logic [63:0] r;
        r      = {$urandom(), $urandom()};
        csb0   = ($urandom_range(0, 2) == 0);
        csb1   = ($urandom_range(0, 2) == 0);
        addr0  = AW'($urandom_range(0, 7));
        addr1  = AW'($urandom_range(0, 7));
        din0   = r[DW-1:0];
        wmask0 = NM'($urandom_range(0, 15));
    endtask

    initial begin
        logic [DW-1:0] v;
        logic [DW-1:0] held;
        int            k;

        idle();
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        sweep_len(k);
        check("sweep_len", 64'(k), 64'd128);

        rd(0, v);   check("clr_rd0",   64'(v), 64'd0);
        rd(64, v);  check("clr_rd64",  64'(v), 64'd0);
        rd(127, v); check("clr_rd127", 64'(v), 64'd0);

        wr(5, 44'hABC_DEF0_1234, 4'b1111);
        rd(5, v);   check("wr_rd5", 64'(v), 64'h0ABC_DEF0_1234);

        wr(9, {DW{1'b1}}, 4'b1111);
        wr(9, '0, 4'b0101);
        rd(9, v);   check("mask_rd9", 64'(v), 64'h0FFE_003F_F800);

        // Same-address read and write: old data returned, one pulse.
        wr(20, 44'h111, 4'b1111);
        csb0 = 1'b0; addr0 = 7'd20; din0 = 44'h222; wmask0 = 4'b1111;
        csb1 = 1'b0; addr1 = 7'd20;
        cycle();
        idle();
        check("coll_old",   64'(bus_a.dout1),         64'h111);
        check("coll_pulse", 64'(bus_a.collision),     64'd1);
        check("coll_cnt1",  64'(bus_a.collision_cnt), 64'd1);
        cycle();
        check("coll_once",  64'(bus_a.collision),     64'd0);
        rd(20, v);  check("coll_new", 64'(v), 64'h222);

        // Five back-to-back collisions drive the 2-bit counter to saturation.
        for (int i = 0; i < 5; i++) begin
            csb0 = 1'b0; addr0 = 7'd30; din0 = DW'(i + 1); wmask0 = 4'b1111;
            csb1 = 1'b0; addr1 = 7'd30;
            cycle();
        end
        idle();
        check("sat_cnt_b", 64'(bus_b.collision_cnt), 64'd3);
        check("cnt_a_6",   64'(bus_a.collision_cnt), 64'd6);
        check("last_rd30", 64'(bus_a.dout1),         64'd4);

        held = bus_a.dout1;
        for (int i = 0; i < 10; i++) begin
            rand_inputs();
            csb1 = 1'b1;
            cycle();
            check("hold_dout", 64'(bus_a.dout1), 64'(held));
        end
        idle();

        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            cycle();
        end
        idle();

        // Reset part-way through a sweep, with user traffic during the sweep.
        wr(40, 44'h5A5_A5A5_A5A5, 4'b1111);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            rand_inputs();
            addr0 = 7'd40;
            cycle();
        end
        idle();
        reset = 1'b1;
        repeat (2) cycle();
        check("rst_ready_low", 64'(bus_a.ready), 64'd0);
        reset = 1'b0;
        k = 0;
        while (k < 300) begin
            rand_inputs();
            cycle();
            k++;
            if (bus_a.ready === 1'b1) break;
        end
        idle();
        check("resweep_len", 64'(k), 64'd128);
        rd(40, v);  check("rst_rd40", 64'(v), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
